systolic_seq_ctrl: RTL and testbench

Sequencer for an N×N output-stationary systolic array of processing elements. It accepts one operand beat per reduction step: a column of A holding one element per array row, and a row of B holding one element per array column. It skews each beat onto the array's left and top edges and drives the array-wide pause and clear controls. It then drains the pipeline and signals when every accumulator holds its final dot product. It sits between the operand fetch logic and the array edge inputs inside the compute unit.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_seq_ctrl_skew_line.sv | 32 +++
 rtl/systolic_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding and default geometry for the systolic array sequencer.
package systolic_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N          = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Enabled delay line of DEPTH registers; DEPTH=0 collapses to a wire.
module skew_line
  import systolic_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, en};
    assign q = d;
  end else begin : g_regs
    logic [DEPTH-1:0][DATA_WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pipe <= '0;
      end else if (en) begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Operand skew / pause / clear sequencer for an NxN output-stationary systolic array.
// Optional stall_cycles counter is built when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int K_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [N*DATA_WIDTH-1:0] op_a,
  input  logic [N*DATA_WIDTH-1:0] op_b,
  output logic [N*DATA_WIDTH-1:0] left_out,
  output logic [N*DATA_WIDTH-1:0] top_out,
  output logic                    pe_pause,
  output logic                    pe_clear,
  output logic                    busy,
  output logic                    done
`ifdef SYSTOLIC_SEQ_PERF_EN
  , output logic [31:0]           stall_cycles
`endif
);
  localparam int DCW = $clog2(2*N);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2*N-3);

  state_t         state;
  logic [K_W-1:0] k_lat;
  logic [K_W-1:0] step;
  logic [DCW-1:0] dcnt;
  logic           pause_q;
  logic           accept;
  logic           stall;
  logic           en;

  assign accept   = (state == FEED) &&  op_valid;
  assign stall    = (state == FEED) && !op_valid;
  // Stalls freeze the array combinationally; all other pause levels come from the FSM.
  assign pe_pause = pause_q | stall;
  assign en       = !pe_pause;

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_in, b_in;
    assign a_in = accept ? op_a[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_in = accept ? op_b[g*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_line #(.DEPTH(g), .DATA_WIDTH(DATA_WIDTH)) u_row (
      .clk(clk), .reset(reset), .en(en),
      .d(a_in), .q(left_out[g*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_line #(.DEPTH(g), .DATA_WIDTH(DATA_WIDTH)) u_col (
      .clk(clk), .reset(reset), .en(en),
      .d(b_in), .q(top_out[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k_lat    <= '0;
      step     <= '0;
      dcnt     <= '0;
      pause_q  <= 1'b1;
      op_ready <= 1'b0;
      pe_clear <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k_lat    <= k_len;
          state    <= CLEAR;
          pe_clear <= 1'b1;
          pause_q  <= 1'b0;
          busy     <= 1'b1;
        end
        CLEAR: begin
          pe_clear <= 1'b0;
          step     <= '0;
          if (k_lat != '0) begin
            state    <= FEED;
            op_ready <= 1'b1;
          end else begin
            state   <= DONE;
            done    <= 1'b1;
            pause_q <= 1'b1;
          end
        end
        FEED: if (accept) begin
          step <= step + K_W'(1);
          if (step == k_lat - K_W'(1)) begin
            state    <= DRAIN;
            op_ready <= 1'b0;
            dcnt     <= '0;
          end
        end
        // 2N-2 cycles lets the last beat reach PE(N-1,N-1).
        DRAIN: begin
          dcnt <= dcnt + DCW'(1);
          if (dcnt == DRAIN_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            pause_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          pause_q  <= 1'b1;
          op_ready <= 1'b0;
          pe_clear <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          stall_cycles <= '0;
    else if (state == IDLE && start)     stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  // default build: no stall counter
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Table-driven tile bench with an edge scoreboard and an output-stationary array model.
module tb_systolic_seq_ctrl;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [N*DW-1:0] op_a = '0, op_b = '0;
  logic [N*DW-1:0] left_out, top_out;
  logic          pe_pause, pe_clear, busy, done;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .N(N), .K_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .left_out(left_out), .top_out(top_out), .pe_pause(pe_pause),
    .pe_clear(pe_clear), .busy(busy), .done(done)
`ifdef SYSTOLIC_SEQ_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int k; int s_lo; int s_hi; bit cdata; int drain_start; int exp_done; int exp_stalls;
  } vec_t;

  typedef struct { int cyc; int lane; bit top; logic [DW-1:0] val; } sb_t;
  sb_t sbq[$];

  logic [DW-1:0] da[16][N];
  logic [DW-1:0] db[16][N];
  logic [31:0]   acc[N][N];
  logic [DW-1:0] ar[N][N];
  logic [DW-1:0] br[N][N];

  // Array of PEs: A flows right, B flows down, products accumulate in place.
  task automatic model_step();
    logic [DW-1:0] nar[N][N];
    logic [DW-1:0] nbr[N][N];
    logic [DW-1:0] a, b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a = (j == 0) ? left_out[i*DW +: DW] : ar[i][j-1];
        b = (i == 0) ? top_out[j*DW +: DW]  : br[i-1][j];
        nar[i][j] = ar[i][j];
        nbr[i][j] = br[i][j];
        if (pe_clear) begin
          acc[i][j] = '0; nar[i][j] = '0; nbr[i][j] = '0;
        end else if (!pe_pause) begin
          acc[i][j] = acc[i][j] + 32'(a) * 32'(b);
          nar[i][j] = a; nbr[i][j] = b;
        end
      end
    ar = nar;
    br = nbr;
  endtask

  task automatic run_tile(input int id, input vec_t v);
    int bi = 0;
    bit nostall = (v.s_lo < 0);
    logic [N*DW-1:0] pl = '0, pt = '0, el, et;
    logic [31:0] c;
    sbq.delete();
    for (int s = 0; s < v.k; s++)
      for (int i = 0; i < N; i++) begin
        da[s][i] = v.cdata ? DW'(1) : DW'($urandom_range(0, 255));
        db[s][i] = v.cdata ? DW'(2) : DW'($urandom_range(0, 255));
      end
    for (int t = 0; t <= v.exp_done + 1; t++) begin
      start    = (t == 0) || (t == v.drain_start);
      k_len    = (t == 0) ? KW'(v.k) : KW'(9);
      op_valid = !(t >= v.s_lo && t <= v.s_hi);
      for (int i = 0; i < N; i++) begin
        op_a[i*DW +: DW] = (bi < v.k) ? da[bi][i] : 16'hDEAD;
        op_b[i*DW +: DW] = (bi < v.k) ? db[bi][i] : 16'hBEEF;
      end
      #1;
      if (op_ready && op_valid) begin
        if (nostall)
          for (int i = 0; i < N; i++) begin
            sbq.push_back('{t + i, i, 1'b0, da[bi][i]});
            sbq.push_back('{t + i, i, 1'b1, db[bi][i]});
          end
        bi++;
      end
      if (nostall) begin
        el = '0; et = '0;
        for (int q = sbq.size() - 1; q >= 0; q--)
          if (sbq[q].cyc == t) begin
            if (sbq[q].top) et[sbq[q].lane*DW +: DW] = sbq[q].val;
            else            el[sbq[q].lane*DW +: DW] = sbq[q].val;
            sbq.delete(q);
          end
        chk($sformatf("tile%0d left_out t=%0d", id, t), left_out, el);
        chk($sformatf("tile%0d top_out t=%0d", id, t), top_out, et);
      end
      chk($sformatf("tile%0d pe_clear t=%0d", id, t), 64'(pe_clear), 64'(t == 1));
      chk($sformatf("tile%0d done t=%0d", id, t), 64'(done), 64'(t == v.exp_done));
      chk($sformatf("tile%0d busy t=%0d", id, t), 64'(busy), 64'(t >= 1 && t <= v.exp_done));
      chk($sformatf("tile%0d pe_pause t=%0d", id, t), 64'(pe_pause),
          64'(t == 0 || t >= v.exp_done || (t >= v.s_lo && t <= v.s_hi)));
      if (t > v.s_lo && t <= v.s_hi) begin
        chk($sformatf("tile%0d hold left t=%0d", id, t), left_out, pl);
        chk($sformatf("tile%0d hold top t=%0d", id, t), top_out, pt);
      end
`ifdef SYSTOLIC_SEQ_PERF_EN
      if (t == 1) chk($sformatf("tile%0d stall_cycles clr", id), 64'(stall_cycles), 64'd0);
`endif
      pl = left_out; pt = top_out;
      model_step();
      @(negedge clk);
    end
    start = 1'b0; op_valid = 1'b0;
    chk($sformatf("tile%0d beats", id), 64'(bi), 64'(v.k));
    chk($sformatf("tile%0d sb_left", id), 64'(sbq.size()), 64'd0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = '0;
        for (int s = 0; s < v.k; s++) c = c + 32'(da[s][i]) * 32'(db[s][j]);
        chk($sformatf("tile%0d acc[%0d][%0d]", id, i, j), 64'(acc[i][j]), 64'(c));
      end
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk($sformatf("tile%0d stall_cycles", id), 64'(stall_cycles), 64'(v.exp_stalls));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " left_out"}, left_out, 64'd0);
    chk({tag, " top_out"}, top_out, 64'd0);
    chk({tag, " op_ready"}, 64'(op_ready), 64'd0);
    chk({tag, " pe_pause"}, 64'(pe_pause), 64'd1);
    chk({tag, " pe_clear"}, 64'(pe_clear), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'd0);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3, -1, -1, 1'b1, -1, 11, 0};  // baseline tile
    vecs[1] = '{3,  3,  4, 1'b1, -1, 13, 2};  // two stall cycles
    vecs[2] = '{0, -1, -1, 1'b1, -1,  2, 0};  // empty reduction
    vecs[3] = '{5, -1, -1, 1'b0,  8, 13, 0};  // start during DRAIN ignored
    vecs[4] = '{1,  2,  2, 1'b0, -1, 10, 1};  // stall on first FEED cycle
    vecs[5] = '{8,  5,  7, 1'b0, -1, 19, 3};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = '0; ar[i][j] = '0; br[i][j] = '0;
      end

    @(negedge clk); #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Abort mid-FEED with an asynchronous reset.
    start = 1'b1; k_len = 8'd4; op_valid = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_abort op_ready", 64'(op_ready), 64'd1);
    reset = 1'b0; #1;
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      chk($sformatf("post_rst busy t=%0d", t), 64'(busy), 64'd0);
      chk($sformatf("post_rst pe_pause t=%0d", t), 64'(pe_pause), 64'd1);
      chk($sformatf("post_rst op_ready t=%0d", t), 64'(op_ready), 64'd0);
      @(negedge clk);
    end

    for (int v = 0; v < 6; v++) run_tile(v, vecs[v]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
